// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared opcodes and elaboration helpers for pipelined_adder
package pipelined_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Chunk width handled by one pipeline stage; 0 flags an illegal stage count
  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 0;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CW-bit ripple adder used by each pipeline stage
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] sum_o,
  output logic          cout_o
);

  // One extra bit on the left captures the chunk carry-out
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - add/sub with the carry chain split into STAGES registered chunks
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Per-stage registers; a/b carry the operands (upper chunks still to add, MSBs for ovf),
  // s holds the partial sum built up one chunk per stage, c is the chunk carry-out.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             v_d [STAGES];

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Whole pipe moves together; it only freezes when a finished result is being refused
  assign out_valid = v_q[STAGES-1];
  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign accept    = in_valid & in_ready;

  // Subtraction as a + ~b + ~cin, so cin acts as borrow-in and cout as NOT borrow
  assign b_eff = (op_sub == OP_SUB) ? ~b : b;
  assign c_eff = (op_sub == OP_SUB) ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic             v_src;
    logic [CW-1:0]    chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] s_next;

    if (k == 0) begin : g_head
      assign a_src = a;
      assign b_src = b_eff;
      assign s_src = '0;
      assign c_src = c_eff;
      assign v_src = accept;
    end else begin : g_body
      assign a_src = a_q[k-1];
      assign b_src = b_q[k-1];
      assign s_src = s_q[k-1];
      assign c_src = c_q[k-1];
      assign v_src = v_q[k-1];
    end

    adder_chunk #(
      .CW(CW)
    ) u_chunk (
      .a_i   (a_src[k*CW +: CW]),
      .b_i   (b_src[k*CW +: CW]),
      .cin_i (c_src),
      .sum_o (chunk_sum),
      .cout_o(chunk_cout)
    );

    // Splice this stage's chunk into the partial sum passed down the pipe
    always_comb begin
      s_next               = s_src;
      s_next[k*CW +: CW]   = chunk_sum;
    end

    assign a_d[k] = a_src;
    assign b_d[k] = b_src;
    assign s_d[k] = s_next;
    assign c_d[k] = chunk_cout;
    assign v_d[k] = v_src;
  end

  // Stage registers: clear on reset, shift forward on advance, hold during a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

  assign sum  = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
                (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's combinational 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands with carry-in.
- Splits the carry chain into STAGES equal chunks, one register stage per chunk, so wide adds close timing.
- Streams operations through a valid/ready handshake with full back-pressure; sits between operand-producing datapath logic and a result consumer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- op_sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add); NOT borrow (sub).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: on rst high, immediately and asynchronously clear every stage valid bit and all data registers to 0. Outputs during/after reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. In-flight operations are discarded and never emitted.
- Operand conditioning at input:
  - b_eff = op_sub ? ~b : b.
  - c_eff = op_sub ? ~cin : cin.
  - So op_sub=1, cin=0 gives a-b; cin=1 gives a-b-1.
- Global stall: advance = out_ready | ~out_valid; in_ready = advance (combinational, no dependence on in_valid).
- Accept occurs when in_valid & in_ready.
- On each advance edge, every stage register loads from its predecessor. Stage 0 loads the accepted beat, or a bubble (valid=0) if none.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff plus the carry from stage k-1 (c_eff for k=0).
  - Stores the chunk sum and carry-out.
  - Forwards the not-yet-added upper chunks of a and b_eff, and the already-computed lower sum chunks, unchanged.
- Latency: the result appears at out_valid exactly STAGES cycles after the accepting edge when out_ready stays 1.
- Throughput: one op per cycle. Bubbles are not compressed; a stall freezes all stages.
- No advance: all stage registers hold; sum/cout/ovf stable while out_valid=1 and out_ready=0.
- cout = carry out of MSB chunk.
- ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]). a[MSB] and b_eff[MSB] are carried through the pipe.
- Width: all arithmetic is modulo 2^WIDTH; no saturation.
- Simultaneous accept and emit in the same cycle is legal and required for full rate.
- in_valid with in_ready=0: beat not taken; the source must hold it.
- STAGES=1: degenerates to a single registered adder, latency 1.

Decomposition:
- Package pipelined_adder_pkg holds OP_ADD=1'b0 and OP_SUB=1'b1, plus a function returning CW for elaboration checks.
- One sub-module, adder_chunk: a purely combinational CW-bit ripple adder (a, b, cin -> sum, cout). It is instantiated once per stage via a generate loop.
- Stage registers, valid chain and stall logic stay in the top.
- Elaboration check: the top errors if WIDTH % STAGES != 0.

Test Plan:
- Basic add, WIDTH=16, STAGES=4: a=0x0003, b=0x0004, cin=0, add -> sum=0x0007, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Full carry ripple across all stages: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
- Subtract: a=0x0005, b=0x0007, op_sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Same with cin=1 -> sum=0xFFFD. Also a=0x8000, b=0x0001, sub -> sum=0x7FFF, ovf=1, cout=1.
- Back-to-back stream plus back-pressure:
  - Issue 8 ops on consecutive cycles with out_ready=1 -> 8 results in order on consecutive cycles.
  - Then drop out_ready for 3 cycles with a result pending -> in_ready=0, sum held stable, no op lost or duplicated.
- Reset mid-operation: accept 3 ops, assert rst asynchronously between edges -> out_valid drops immediately, sum=0. After release, no stale result is emitted; a new op a=0x1234, b=0x1111 gives 0x2345 after 4 cycles.
- Parameter sweep: WIDTH=4 STAGES=1 and WIDTH=32 STAGES=8, random ops against a reference model -> all results match, with latency equal to STAGES.
